lut_access_ctrl: RTL

- Controller and arbiter for the 6-entry x 2-bit f/g lookup table.
- Owns the table storage and shares its single access port between two requesters.
  - A configuration writer reprograms entries.
  - A lookup reader fetches an entry and drives registered f/g outputs.
- Sequenced by a 4-state FSM with round-robin arbitration between the two requesters.

---
 rtl/lut_access_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lut_access_ctrl.sv
// Arbitrated controller for the small f/g lookup table: one shared access port,
// a configuration writer and a lookup reader, round-robin between the two.
module lut_access_ctrl #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 2,
  parameter int AW    = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_gnt,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic             f,
  output logic             g,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Handshake: a requester raises req with addr/data stable and holds it until
  // its one-cycle gnt; addr/data are sampled only on the IDLE edge that grants.
  // A req still high when the FSM is back in IDLE counts as a new request.

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             prio_rd_q, prio_rd_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] rd_entry;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic [WIDTH-1:0] default_entry(input int idx);
    case (idx)
      0:       return WIDTH'(2'b01);
      1:       return WIDTH'(2'b10);
      2:       return WIDTH'(2'b11);
      3:       return WIDTH'(2'b00);
      4:       return WIDTH'(2'b01);
      5:       return WIDTH'(2'b11);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    prio_rd_d = prio_rd_q;
    case (state_q)
      S_IDLE: begin
        // Write wins when it is the only requester or when it holds priority.
        if (wr_req && (!rd_req || !prio_rd_q)) begin
          state_d   = S_WR;
          addr_d    = wr_addr;
          data_d    = wr_data;
          prio_rd_d = 1'b1;
        end else if (rd_req) begin
          state_d   = S_RD;
          addr_d    = rd_addr;
          prio_rd_d = 1'b0;
        end
      end
      S_WR:    state_d = S_IDLE;
      S_RD:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_entry = '0;
    if (in_range(addr_q)) rd_entry = table_q[addr_q];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      prio_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= default_entry(i);
    end else if (state_q == S_WR && in_range(addr_q)) begin
      table_q[addr_q] <= data_q;
    end
  end

  // Outputs are decoded from the next state so each one is a flop aligned
  // with the state it describes.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_gnt   <= 1'b0;
      rd_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      f        <= 1'b0;
      g        <= 1'b0;
    end else begin
      wr_gnt   <= (state_d == S_WR);
      rd_gnt   <= (state_d == S_RD);
      rd_valid <= (state_d == S_RESP);
      busy     <= (state_d != S_IDLE);
      err      <= ((state_d == S_WR) || (state_d == S_RD)) && !in_range(addr_d);
      if (state_q == S_RD) begin
        f <= rd_entry[1];
        g <= rd_entry[0];
      end
    end
  end

  assign dbg_state = state_q;

endmodule
